// File: rtl/ascon_ctrl_regs.sv
// ---------------------------------------------------------------------------
// ascon_ctrl_regs
//
// Register front-end for the ASCON permutation core. Bridges a simple
// register bus to the core's start/finished handshake, exposes the whole
// permutation state as bus words and adds a run/done state machine, an
// interrupt, a busy-write guard that reports a bus error, and a saturating
// run-cycle counter.
//
// Parameters
//   LANES      number of 64-bit state lanes
//   BUS_W      bus data width (32 or 64); each lane is 64/BUS_W words
//   reg_req_t  bus request type  {valid, write, addr, wdata, wstrb}
//   reg_rsp_t  bus response type {ready, rdata, error}
//
// Ports
//   clk_i           clock, rising edge
//   rst_n_i         asynchronous active-low reset
//   reg_req_i       bus request
//   reg_rsp_o       bus response (combinational in the request cycle)
//   start_o         one-cycle start pulse to the core (first cycle of RUN)
//   finished_i      core completion pulse (honoured only in RUN)
//   update_state_i  load state_i into the lanes (honoured only in RUN)
//   state_i         core output state, lane i at [i*64 +: 64]
//   state_o         lane registers driven to the core
//   irq_o           level interrupt = DONE & IRQ_EN
//
// Byte address map
//   0x00 CTRL    bit0 START (w1 pulse), bit1 IRQ_EN (rw), bit2 DONE_CLR (w1 pulse)
//   0x04 STATUS  bit0 BUSY, bit1 DONE, bit2 ERR
//   0x08 CYCLES  RUN cycles of the last/current run, saturating
//   0x10 + (i*WPL + j)*(BUS_W/8)  lane i, word j (j=0 least significant)
// ---------------------------------------------------------------------------
package reg_pkg;
    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reg_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } reg_rsp_t;
endpackage

module ascon_ctrl_regs #(
    parameter int  LANES     = 5,
    parameter int  BUS_W     = 32,
    parameter type reg_req_t = reg_pkg::reg_req_t,
    parameter type reg_rsp_t = reg_pkg::reg_rsp_t
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  reg_req_t              reg_req_i,
    output reg_rsp_t              reg_rsp_o,
    output logic                  start_o,
    input  logic                  finished_i,
    input  logic                  update_state_i,
    input  logic [LANES*64-1:0]   state_i,
    output logic [LANES*64-1:0]   state_o,
    output logic                  irq_o
);

    localparam int WPL    = 64 / BUS_W;
    localparam int BPW    = BUS_W / 8;
    localparam int ALIGN  = $clog2(BPW);
    localparam int NWORDS = LANES * WPL;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic               start_reg, start_next;
    logic               done_reg, done_next;
    logic               err_reg, err_next;
    logic               irq_en_reg;
    logic [BUS_W-1:0]   cycles_reg, cycles_next;
    logic [LANES*64-1:0] lanes_flat;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0]      addr;
    logic [BUS_W-1:0] wdata;
    logic [BPW-1:0]   wstrb;
    logic [31:0]      off;
    logic [31:0]      word_idx;
    logic             ctrl_hit, status_hit, cycles_hit, lane_hit, unmapped;
    logic             wr;

    assign addr     = reg_req_i.addr;
    assign wdata    = reg_req_i.wdata;
    assign wstrb    = reg_req_i.wstrb;
    assign off      = addr - 32'h10;
    assign word_idx = off >> ALIGN;

    assign ctrl_hit   = (addr == 32'h00);
    assign status_hit = (addr == 32'h04);
    assign cycles_hit = (addr == 32'h08);
    assign lane_hit   = (addr >= 32'h10) && (off[ALIGN-1:0] == '0) &&
                        (word_idx < 32'(NWORDS));
    assign unmapped   = !(ctrl_hit || status_hit || cycles_hit || lane_hit);

    assign wr = reg_req_i.valid && reg_req_i.write;

    // All CTRL bits live in byte 0, so only wstrb[0] gates them.
    logic ctrl_wr, start_req, clr_req, busy_wr_err, lane_wr_ok, core_load;

    assign ctrl_wr   = wr && ctrl_hit;
    assign start_req = ctrl_wr && wstrb[0] && wdata[0];
    assign clr_req   = ctrl_wr && wstrb[0] && wdata[2];

    // While the core runs, the lanes and START are locked; such writes are
    // dropped and flagged. IRQ_EN / DONE_CLR in the same write still apply.
    assign busy_wr_err = wr && (state_reg == ST_RUN) && (lane_hit || start_req);
    assign lane_wr_ok  = wr && lane_hit && (state_reg != ST_RUN);
    assign core_load   = (state_reg == ST_RUN) && (finished_i || update_state_i);

    // ------------------------------------------------------------------
    // Lane registers with per-byte write enables
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [63:0] lane_reg;
        logic [7:0]  byte_we;

        for (genvar gj = 0; gj < 8; gj++) begin : g_byte
            assign byte_we[gj] = lane_wr_ok &&
                                 (word_idx == 32'(gi * WPL + gj / BPW)) &&
                                 wstrb[gj % BPW];
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                lane_reg <= '0;
            end else if (core_load) begin
                lane_reg <= state_i[gi*64 +: 64];
            end else begin
                for (int b = 0; b < 8; b++) begin
                    if (byte_we[b]) begin
                        lane_reg[b*8 +: 8] <= wdata[(b % BPW)*8 +: 8];
                    end
                end
            end
        end

        assign lanes_flat[gi*64 +: 64] = lane_reg;
    end

    assign state_o = lanes_flat;

    // ------------------------------------------------------------------
    // Run/done FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        start_next  = 1'b0;
        done_next   = done_reg;
        err_next    = err_reg;
        cycles_next = cycles_reg;

        if (clr_req) begin
            done_next = 1'b0;
            err_next  = 1'b0;
        end

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                // START beats a DONE_CLR carried in the same write.
                if (start_req) begin
                    state_next  = ST_RUN;
                    start_next  = 1'b1;
                    done_next   = 1'b0;
                    cycles_next = '0;
                end else if (state_reg == ST_DONE && clr_req) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cycles_reg != '1) begin
                    cycles_next = cycles_reg + BUS_W'(1);
                end
                // Evaluated after DONE_CLR so a coincident completion wins.
                if (finished_i) begin
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (busy_wr_err) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            start_reg  <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            cycles_reg <= '0;
            irq_en_reg <= 1'b0;
        end else begin
            start_reg  <= start_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
            cycles_reg <= cycles_next;
            if (ctrl_wr && wstrb[0]) begin
                irq_en_reg <= wdata[1];
            end
        end
    end

    assign start_o = start_reg;
    assign irq_o   = done_reg && irq_en_reg;

    // ------------------------------------------------------------------
    // Read mux and bus response
    // ------------------------------------------------------------------
    logic [BUS_W-1:0] rdata_mux;

    always_comb begin
        rdata_mux = '0;
        if (ctrl_hit) begin
            rdata_mux[1] = irq_en_reg;
        end else if (status_hit) begin
            rdata_mux[2:0] = {err_reg, done_reg, state_reg == ST_RUN};
        end else if (cycles_hit) begin
            rdata_mux = cycles_reg;
        end else if (lane_hit) begin
            for (int i = 0; i < LANES; i++) begin
                for (int j = 0; j < WPL; j++) begin
                    if (word_idx == 32'(i * WPL + j)) begin
                        rdata_mux = lanes_flat[(i*64 + j*BUS_W) +: BUS_W];
                    end
                end
            end
        end
    end

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = reg_req_i.valid;
        if (reg_req_i.valid) begin
            reg_rsp_o.error = unmapped || busy_wr_err;
            reg_rsp_o.rdata = unmapped ? '0 : rdata_mux;
        end
    end

endmodule
